ula_lsl_lsr_seq: RTL and testbench

ULA_LSL_LSR_SEQ -- requirements
Module: ula_lsl_lsr_seq

---
 rtl/ula_seq_pkg.sv | 28 ++
 rtl/ula_seq_core.sv | 34 +++
 rtl/ula_lsl_lsr_seq.sv | 106 ++++++++++
 tb/tb_ula_lsl_lsr_seq.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_seq_pkg.sv
// Shared constants for the sequential ALU with multi-cycle LSL/LSR.
// Op codes, FSM state encoding, data width and shift saturation limit.
package ula_seq_pkg;

  localparam int W         = 4;
  localparam int SHIFT_SAT = 4;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOTA = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_LSL  = 3'b110;
  localparam logic [2:0] OP_LSR  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Shift amount clamped to SHIFT_SAT, so the counter fits in 3 bits.
  function automatic logic [2:0] sat_amt(input logic [W-1:0] b);
    sat_amt = (b > W'(SHIFT_SAT)) ? 3'(SHIFT_SAT) : b[2:0];
  endfunction

endpackage

// File: rtl/ula_seq_core.sv
// Combinational single-cycle ALU ops (logic, add, sub).
// Shift opcodes pass A through so the FSM can load it as the shift seed.
module ula_seq_core
  import ula_seq_pkg::*;
(
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic [2:0]   op_sel,
  output logic [W-1:0] y_out,
  output logic         c_out
);

  logic [W:0] w_sum;
  logic [W:0] w_diff;

  assign w_sum  = {1'b0, a_in} + {1'b0, b_in};
  assign w_diff = {1'b0, a_in} - {1'b0, b_in};

  always_comb begin
    y_out = a_in;
    c_out = 1'b0;
    case (op_sel)
      OP_AND:  y_out = a_in & b_in;
      OP_OR:   y_out = a_in | b_in;
      OP_NOTA: y_out = ~a_in;
      OP_NAND: y_out = ~(a_in & b_in);
      OP_ADD:  begin y_out = w_sum[W-1:0];  c_out = w_sum[W];  end
      // w_diff[W] is the borrow, i.e. A < B
      OP_SUB:  begin y_out = w_diff[W-1:0]; c_out = w_diff[W]; end
      default: y_out = a_in;
    endcase
  end

endmodule

// File: rtl/ula_lsl_lsr_seq.sv
// Sequential ALU: single-cycle ops via ula_seq_core, LSL/LSR one bit per cycle.
// Optional zero/carry flag outputs enabled by ULA_SEQ_FLAGS_EN.
module ula_lsl_lsr_seq
  import ula_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid_in,
  output logic         cmd_ready_out,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic [2:0]   op_sel,
  output logic         res_valid_out,
  input  logic         res_ready_in,
  output logic [W-1:0] resultado_out,
`ifdef ULA_SEQ_FLAGS_EN
  output logic         zero_out,
  output logic         carry_out,
`endif
  output logic         busy_out
);

  state_e       r_state;
  logic [W-1:0] r_res;
  logic [2:0]   r_cnt;
  logic         r_dir_right;

  logic [W-1:0] w_core_y;
  logic         w_core_c;
  logic [2:0]   w_amt;
  logic         w_is_shift;
  logic [W-1:0] w_shift_nxt;
  logic         w_shift_out;

  ula_seq_core u_core (
    .a_in   (a_in),
    .b_in   (b_in),
    .op_sel (op_sel),
    .y_out  (w_core_y),
    .c_out  (w_core_c)
  );

  assign w_amt       = sat_amt(b_in);
  assign w_is_shift  = (op_sel[2:1] == 2'b11);
  assign w_shift_nxt = r_dir_right ? {1'b0, r_res[W-1:1]} : {r_res[W-2:0], 1'b0};
  assign w_shift_out = r_dir_right ? r_res[0] : r_res[W-1];

`ifdef ULA_SEQ_FLAGS_EN
  logic r_zero;
  logic r_carry;
  assign zero_out  = r_zero;
  assign carry_out = r_carry;
`else
  logic w_unused_flags;
  assign w_unused_flags = w_core_c ^ w_shift_out;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_res       <= '0;
      r_cnt       <= '0;
      r_dir_right <= 1'b0;
`ifdef ULA_SEQ_FLAGS_EN
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (cmd_valid_in) begin
          // Shift ops seed r_res with A; core passes A through for them.
          r_res       <= w_core_y;
          r_dir_right <= op_sel[0];
`ifdef ULA_SEQ_FLAGS_EN
          r_zero      <= (w_core_y == '0);
          r_carry     <= w_core_c;
`endif
          if (w_is_shift && (w_amt != 3'd0)) begin
            r_cnt   <= w_amt;
            r_state <= S_SHIFT;
          end else begin
            r_cnt   <= 3'd0;
            r_state <= S_DONE;
          end
        end
        S_SHIFT: begin
          r_res <= w_shift_nxt;
          r_cnt <= r_cnt - 3'd1;
`ifdef ULA_SEQ_FLAGS_EN
          r_zero  <= (w_shift_nxt == '0);
          r_carry <= w_shift_out;
`endif
          if (r_cnt == 3'd1) r_state <= S_DONE;
        end
        S_DONE: if (res_ready_in) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_out = (r_state == S_IDLE);
  assign res_valid_out = (r_state == S_DONE);
  assign busy_out      = (r_state != S_IDLE);
  assign resultado_out = r_res;

endmodule

// File: tb/tb_ula_lsl_lsr_seq.sv
// Directed bench for ula_lsl_lsr_seq: reset, ops, latency, backpressure, sweep.
// Flag checks are compiled in when ULA_SEQ_FLAGS_EN is defined.
module tb_ula_lsl_lsr_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid_in = 1'b0;
  logic       cmd_ready_out;
  logic [3:0] a_in = 4'd0;
  logic [3:0] b_in = 4'd0;
  logic [2:0] op_sel = 3'd0;
  logic       res_valid_out;
  logic       res_ready_in = 1'b1;
  logic [3:0] resultado_out;
  logic       busy_out;
`ifdef ULA_SEQ_FLAGS_EN
  logic       zero_out;
  logic       carry_out;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ula_lsl_lsr_seq dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid_in  (cmd_valid_in),
    .cmd_ready_out (cmd_ready_out),
    .a_in          (a_in),
    .b_in          (b_in),
    .op_sel        (op_sel),
    .res_valid_out (res_valid_out),
    .res_ready_in  (res_ready_in),
    .resultado_out (resultado_out),
`ifdef ULA_SEQ_FLAGS_EN
    .zero_out      (zero_out),
    .carry_out     (carry_out),
`endif
    .busy_out      (busy_out)
  );

  // Reference: {carry, zero, latency[3:0], result[3:0]} built from plain arithmetic.
  function automatic logic [9:0] ref_model(input logic [3:0] a, input logic [3:0] b,
                                            input logic [2:0] op);
    int k;
    int y;
    int c;
    int lat;
    k   = (b > 4) ? 4 : int'(b);
    c   = 0;
    lat = 1;
    case (op)
      3'b000: y = a & b;
      3'b001: y = a | b;
      3'b010: y = ~a & 4'hF;
      3'b011: y = ~(a & b) & 4'hF;
      3'b100: begin y = (a + b) & 15; c = ((int'(a) + int'(b)) > 15) ? 1 : 0; end
      3'b101: begin y = (a - b) & 15; c = (a < b) ? 1 : 0; end
      3'b110: begin
        y = (int'(a) << k) & 15;
        if (k > 0) begin c = (int'(a) >> (4 - k)) & 1; lat = k + 1; end
      end
      default: begin
        y = int'(a) >> k;
        if (k > 0) begin c = (int'(a) >> (k - 1)) & 1; lat = k + 1; end
      end
    endcase
    ref_model = {c[0], (y == 0), 4'(lat), 4'(y)};
  endfunction

  // Issue one command; returns edges-to-valid and the captured outputs.
  task automatic run_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                         output int lat, output logic [3:0] res,
                         output logic cy, output logic zr);
    @(negedge clk);
    a_in = a; b_in = b; op_sel = op; cmd_valid_in = 1'b1;
    @(posedge clk); #1;
    cmd_valid_in = 1'b0;
    a_in = ~a; b_in = ~b; op_sel = ~op;
    lat = 1;
    while (res_valid_out !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = resultado_out;
`ifdef ULA_SEQ_FLAGS_EN
    cy = carry_out; zr = zero_out;
`else
    cy = 1'b0; zr = 1'b0;
`endif
    if (res_ready_in) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (resultado_out !== 4'h0 || res_valid_out !== 1'b0 || busy_out !== 1'b0 ||
        cmd_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_values res=%b vld=%b busy=%b rdy=%b, want 0000 0 0 1",
               resultado_out, res_valid_out, busy_out, cmd_ready_out);
    end
`ifdef ULA_SEQ_FLAGS_EN
    checks++;
    if (zero_out !== 1'b0 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags z=%b c=%b, want 0 0", zero_out, carry_out);
    end
`endif
    // First edge after release must accept.
    @(negedge clk);
    rst = 1'b0;
    a_in = 4'b0011; b_in = 4'b0101; op_sel = 3'b000; cmd_valid_in = 1'b1;
    @(posedge clk); #1;
    cmd_valid_in = 1'b0;
    checks++;
    if (res_valid_out !== 1'b1 || resultado_out !== 4'b0001) begin
      errors++;
      $display("FAIL first_accept vld=%b res=%b, want 1 0001", res_valid_out, resultado_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    int lat; logic [3:0] res; logic cy; logic zr;
    run_cmd(4'b1001, 4'b1000, 3'b100, lat, res, cy, zr);
    checks++;
    if (lat !== 1 || res !== 4'b0001) begin
      errors++;
      $display("FAIL add lat=%0d res=%b, want 1 0001", lat, res);
    end
`ifdef ULA_SEQ_FLAGS_EN
    checks++;
    if (cy !== 1'b1 || zr !== 1'b0) begin
      errors++;
      $display("FAIL add_flags c=%b z=%b, want 1 0", cy, zr);
    end
`endif
  endtask

  task automatic test_shifts;
    int lat; logic [3:0] res; logic cy; logic zr;
    run_cmd(4'b1010, 4'b1001, 3'b110, lat, res, cy, zr);
    checks++;
    if (lat !== 5 || res !== 4'b0000) begin
      errors++;
      $display("FAIL lsl_sat lat=%0d res=%b, want 5 0000", lat, res);
    end
`ifdef ULA_SEQ_FLAGS_EN
    checks++;
    if (zr !== 1'b1 || cy !== 1'b0) begin
      errors++;
      $display("FAIL lsl_sat_flags z=%b c=%b, want 1 0", zr, cy);
    end
`endif
    run_cmd(4'b0110, 4'b0010, 3'b111, lat, res, cy, zr);
    checks++;
    if (lat !== 3 || res !== 4'b0001) begin
      errors++;
      $display("FAIL lsr lat=%0d res=%b, want 3 0001", lat, res);
    end
`ifdef ULA_SEQ_FLAGS_EN
    checks++;
    if (cy !== 1'b1 || zr !== 1'b0) begin
      errors++;
      $display("FAIL lsr_flags c=%b z=%b, want 1 0", cy, zr);
    end
`endif
    run_cmd(4'b1011, 4'b0000, 3'b110, lat, res, cy, zr);
    checks++;
    if (lat !== 1 || res !== 4'b1011 || cy !== 1'b0) begin
      errors++;
      $display("FAIL lsl_zero lat=%0d res=%b c=%b, want 1 1011 0", lat, res, cy);
    end
    run_cmd(4'b1001, 4'b0001, 3'b110, lat, res, cy, zr);
    checks++;
    if (lat !== 2 || res !== 4'b0010) begin
      errors++;
      $display("FAIL lsl_one lat=%0d res=%b, want 2 0010", lat, res);
    end
  endtask

  task automatic test_reset_mid_shift;
    int bad;
    res_ready_in = 1'b1;
    @(negedge clk);
    a_in = 4'b0001; b_in = 4'b0011; op_sel = 3'b110; cmd_valid_in = 1'b1;
    @(posedge clk); #1;
    cmd_valid_in = 1'b0;
    checks++;
    if (busy_out !== 1'b1 || res_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL in_shift busy=%b vld=%b, want 1 0", busy_out, res_valid_out);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (resultado_out !== 4'h0 || res_valid_out !== 1'b0 || busy_out !== 1'b0 ||
        cmd_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL midshift_reset res=%b vld=%b busy=%b rdy=%b, want 0000 0 0 1",
               resultado_out, res_valid_out, busy_out, cmd_ready_out);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (res_valid_out !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL no_pulse_after_reset valid_cycles=%0d, want 0", bad);
    end
  endtask

  task automatic test_backpressure;
    int bad;
    res_ready_in = 1'b0;
    @(negedge clk);
    a_in = 4'b0101; b_in = 4'b0000; op_sel = 3'b010; cmd_valid_in = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (res_valid_out !== 1'b1 || resultado_out !== 4'b1010) begin
      errors++;
      $display("FAIL nota vld=%b res=%b, want 1 1010", res_valid_out, resultado_out);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_in = 4'(i * 3 + 1); b_in = 4'(i + 7); op_sel = 3'(i + 4); cmd_valid_in = 1'b1;
      @(posedge clk); #1;
      if (resultado_out !== 4'b1010 || res_valid_out !== 1'b1 || cmd_ready_out !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold bad_cycles=%0d, want 0", bad);
    end
    // Release edge must not also accept the pending command.
    @(negedge clk);
    res_ready_in = 1'b1;
    a_in = 4'b0000; b_in = 4'b0000; op_sel = 3'b001; cmd_valid_in = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (res_valid_out !== 1'b0 || busy_out !== 1'b0 || cmd_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL release vld=%b busy=%b rdy=%b, want 0 0 1",
               res_valid_out, busy_out, cmd_ready_out);
    end
    @(posedge clk); #1;
    cmd_valid_in = 1'b0;
    checks++;
    if (res_valid_out !== 1'b1 || resultado_out !== 4'b0000) begin
      errors++;
      $display("FAIL accept_after_release vld=%b res=%b, want 1 0000",
               res_valid_out, resultado_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep;
    int lat; logic [3:0] res; logic cy; logic zr;
    logic [9:0] exp;
    res_ready_in = 1'b1;
    for (int op = 0; op < 8; op++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          exp = ref_model(4'(a), 4'(b), 3'(op));
          run_cmd(4'(a), 4'(b), 3'(op), lat, res, cy, zr);
          checks++;
          if (res !== exp[3:0] || lat != int'(exp[7:4])) begin
            errors++;
            $display("FAIL sweep op=%0d a=%0d b=%0d res=%b lat=%0d, want %b %0d",
                     op, a, b, res, lat, exp[3:0], exp[7:4]);
          end
`ifdef ULA_SEQ_FLAGS_EN
          checks++;
          if (cy !== exp[9] || zr !== exp[8]) begin
            errors++;
            $display("FAIL sweep_flags op=%0d a=%0d b=%0d c=%b z=%b, want %b %b",
                     op, a, b, cy, zr, exp[9], exp[8]);
          end
`endif
        end
  endtask

  initial begin
    test_reset;
    test_add;
    test_shifts;
    test_reset_mid_shift;
    test_backpressure;
    test_sweep;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
